// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage access unit: access size, data-bus request/response, FSM states.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } mau_state_t;

  function automatic logic is_misaligned(input msize_t size, input logic [1:0] off);
    return ((size == MSIZE2) && off[0]) || ((size == MSIZE4) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus port bundle: the unit drives dreq as master, the memory side answers on dresp.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobe/data shift and load extract with sign/zero extend.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  msize_t      i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic        i_st_write,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_strobe,
  output logic [31:0] o_st_data,
  input  msize_t      i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_signed,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_ld_sh;

  always_comb begin
    o_st_data   = i_st_wdata << {i_st_off, 3'b000};
    o_st_strobe = 4'b0000;
    if (i_st_write) begin
      case (i_st_size)
        MSIZE1:  o_st_strobe = 4'b0001 << i_st_off;
        MSIZE2:  o_st_strobe = 4'b0011 << i_st_off;
        default: o_st_strobe = 4'b1111;
      endcase
    end
  end

  assign w_ld_sh = i_ld_raw >> {i_ld_off, 3'b000};

  always_comb begin
    case (i_ld_size)
      MSIZE1:  o_ld_data = {{24{i_ld_signed & w_ld_sh[7]}}, w_ld_sh[7:0]};
      MSIZE2:  o_ld_data = {{16{i_ld_signed & w_ld_sh[15]}}, w_ld_sh[15:0]};
      default: o_ld_data = w_ld_sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: accept -> REQ -> (WAIT) -> HOLD; 2 cycles to out_valid on a same-cycle bus reply, 1 for non-memory/misaligned ops.
// Stalls the execute stage (in_ready=0) while a bus access is outstanding or the result is not yet consumed.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_read,
  input  logic        in_write,
  input  msize_t      in_size,
  input  logic        in_signed,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_exc,
  mem_access_unit_if.master dbus
);

  mau_state_t  r_state;
  logic [31:0] r_addr;
  msize_t      r_size;
  logic        r_signed;
  logic        r_read;
  logic [3:0]  r_strobe;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_exc;

  mau_state_t  w_next_state;
  mau_state_t  w_acc_state;
  logic        w_accept;
  logic        w_mem_op;
  logic        w_misal;
  logic        w_done;
  logic [3:0]  w_st_strobe;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_data;

  mem_lane_align u_align (
    .i_st_size   (in_size),
    .i_st_off    (in_addr[1:0]),
    .i_st_write  (in_write),
    .i_st_wdata  (in_wdata),
    .o_st_strobe (w_st_strobe),
    .o_st_data   (w_st_data),
    .i_ld_size   (r_size),
    .i_ld_off    (r_addr[1:0]),
    .i_ld_signed (r_signed),
    .i_ld_raw    (dbus.dresp.data),
    .o_ld_data   (w_ld_data)
  );

  assign in_ready = (r_state == S_IDLE) ||
                    (BACK_TO_BACK && (r_state == S_HOLD) && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_mem_op = in_read || in_write;
  assign w_misal  = is_misaligned(in_size, in_addr[1:0]);
  // Misaligned and non-memory ops never touch the bus; they go straight to HOLD.
  assign w_acc_state = (w_mem_op && !w_misal) ? S_REQ : S_HOLD;

  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = w_acc_state;
      S_REQ: begin
        if (dbus.dresp.addr_ok) begin
          w_next_state = dbus.dresp.data_ok ? S_HOLD : S_WAIT;
          w_done       = dbus.dresp.data_ok;
        end
      end
      S_WAIT: begin
        if (dbus.dresp.data_ok) begin
          w_next_state = S_HOLD;
          w_done       = 1'b1;
        end
      end
      S_HOLD: if (out_ready) w_next_state = w_accept ? w_acc_state : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_size   <= MSIZE1;
      r_signed <= 1'b0;
      r_read   <= 1'b0;
      r_strobe <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_exc    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr   <= in_addr;
        r_size   <= in_size;
        r_signed <= in_signed;
        r_read   <= in_read;
        r_strobe <= w_st_strobe;
        r_wdata  <= w_st_data;
        r_rdata  <= '0;
        r_exc    <= w_mem_op && w_misal;
      end else if (w_done) begin
        r_rdata <= r_read ? w_ld_data : 32'd0;
      end
    end
  end

  // Request fields come straight from the accept-time latches, so they hold until addr_ok.
  assign dbus.dreq = '{valid:  (r_state == S_REQ),
                       addr:   r_addr,
                       size:   r_size,
                       strobe: r_strobe,
                       data:   r_wdata};

  assign out_valid = (r_state == S_HOLD);
  assign out_rdata = r_rdata;
  assign out_exc   = r_exc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized ops against a byte-level memory model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_read = 1'b0;
  logic        in_write = 1'b0;
  msize_t      in_size = MSIZE1;
  logic        in_signed = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_exc;

  int checks = 0;
  int errors = 0;

  int          rsp_addr_dly = 0;
  int          rsp_data_dly = 0;
  logic        rsp_force_en = 1'b0;
  logic [31:0] rsp_force_data = '0;
  logic        man_en = 1'b0;
  dbus_resp_t  man_dresp = '0;
  dbus_resp_t  rsp_dresp = '0;
  logic [31:0] mem_bus [16];
  logic [31:0] mem_ref [16];

  mem_access_unit_if dbus ();

  assign dbus.dresp = man_en ? man_dresp : rsp_dresp;

  mem_access_unit #(.BACK_TO_BACK(1'b1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_read   (in_read),
    .in_write  (in_write),
    .in_size   (in_size),
    .in_signed (in_signed),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rdata (out_rdata),
    .out_exc   (out_exc),
    .dbus      (dbus)
  );

  always #5 clk = ~clk;

  // Bus slave: addr_ok after rsp_addr_dly REQ cycles, data_ok rsp_data_dly cycles after that.
  initial begin : responder
    bit          aphase;
    bit          pend;
    int          acnt;
    int          dcnt;
    logic [31:0] rd;
    logic [3:0]  idx;
    aphase = 0; pend = 0; acnt = 0; dcnt = 0; rd = '0;
    for (int i = 0; i < 16; i++) mem_bus[i] = $urandom;
    forever begin
      @(posedge clk);
      #1;
      rsp_dresp = '0;
      if (man_en || !resetn) begin
        aphase = 0;
        pend   = 0;
      end else if (pend) begin
        if (dcnt == 0) begin
          rsp_dresp.data_ok = 1'b1;
          rsp_dresp.data    = rd;
          pend = 0;
        end else dcnt--;
      end else if (dbus.dreq.valid) begin
        if (!aphase) begin
          aphase = 1;
          acnt   = rsp_addr_dly;
        end
        if (acnt == 0) begin
          aphase = 0;
          rsp_dresp.addr_ok = 1'b1;
          idx = dbus.dreq.addr[5:2];
          rd  = rsp_force_en ? rsp_force_data : mem_bus[idx];
          for (int b = 0; b < 4; b++)
            if (dbus.dreq.strobe[b]) mem_bus[idx][8*b +: 8] = dbus.dreq.data[8*b +: 8];
          if (rsp_data_dly == 0) begin
            rsp_dresp.data_ok = 1'b1;
            rsp_dresp.data    = rd;
          end else begin
            pend = 1;
            dcnt = rsp_data_dly - 1;
          end
        end else acnt--;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one op at a negedge, follows it to HOLD, optionally stalls out_ready, then consumes it.
  task automatic run_op(input logic rd, input logic wr, input msize_t sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd, input int hold_cyc,
                        output logic [31:0] rdata, output logic exc, output int lat,
                        output int vld, output dbus_req_t snap, output bit stable,
                        output bit hold_ok);
    int n;
    stable = 1; hold_ok = 1; vld = 0; lat = 0; snap = '0; rdata = '0; exc = 1'b0;
    in_read = rd; in_write = wr; in_size = sz; in_signed = sg; in_addr = ad; in_wdata = wd;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=%0b want 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (lat < 100) begin
      if (dbus.dreq.valid) begin
        if (vld == 0) snap = dbus.dreq;
        else if (dbus.dreq !== snap) stable = 0;
        vld++;
      end
      if (out_valid) break;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout out_valid=%0b want 1", out_valid);
      return;
    end
    rdata = out_rdata;
    exc   = out_exc;
    repeat (hold_cyc) begin
      @(negedge clk);
      if (!out_valid || out_rdata !== rdata || out_exc !== exc || in_ready !== 1'b0 || dbus.dreq.valid)
        hold_ok = 0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dbus.dreq !== '0) begin
      errors++; $display("FAIL reset_dreq got %h want 0", dbus.dreq);
    end
    checks++;
    if ({out_valid, out_exc, out_rdata} !== 34'd0) begin
      errors++; $display("FAIL reset_out got v=%b e=%b d=%h want 0", out_valid, out_exc, out_rdata);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle got rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_lw;
    logic [31:0] rdata; logic exc; int lat, vld; dbus_req_t snap; bit stable, hold_ok;
    rsp_addr_dly = 0; rsp_data_dly = 0;
    rsp_force_en = 1'b1; rsp_force_data = 32'hDEAD_BEEF;
    run_op(1'b1, 1'b0, MSIZE4, 1'b0, 32'h8000_0010, 32'h0, 0, rdata, exc, lat, vld, snap, stable, hold_ok);
    rsp_force_en = 1'b0;
    checks++;
    if (rdata !== 32'hDEAD_BEEF || exc !== 1'b0) begin
      errors++; $display("FAIL lw_data got %h exc=%b want deadbeef exc=0", rdata, exc);
    end
    checks++;
    if (lat !== 2 || vld !== 1) begin
      errors++; $display("FAIL lw_timing got lat=%0d vld=%0d want 2/1", lat, vld);
    end
    checks++;
    if (snap.addr !== 32'h8000_0010 || snap.strobe !== 4'b0000 || snap.size !== MSIZE4) begin
      errors++; $display("FAIL lw_req got a=%h s=%b z=%0d want 80000010/0000/2", snap.addr, snap.strobe, snap.size);
    end
  endtask

  task automatic test_lb;
    logic [31:0] rdata; logic exc; int lat, vld; dbus_req_t snap; bit stable, hold_ok;
    rsp_addr_dly = 0; rsp_data_dly = 1;
    rsp_force_en = 1'b1; rsp_force_data = 32'h80FF_0000;
    run_op(1'b1, 1'b0, MSIZE1, 1'b1, 32'h8000_0013, 32'h0, 0, rdata, exc, lat, vld, snap, stable, hold_ok);
    checks++;
    if (rdata !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_signed got %h want ffffff80", rdata);
    end
    run_op(1'b1, 1'b0, MSIZE1, 1'b0, 32'h8000_0013, 32'h0, 0, rdata, exc, lat, vld, snap, stable, hold_ok);
    checks++;
    if (rdata !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu got %h want 00000080", rdata);
    end
    run_op(1'b1, 1'b0, MSIZE2, 1'b1, 32'h8000_0012, 32'h0, 0, rdata, exc, lat, vld, snap, stable, hold_ok);
    rsp_force_en = 1'b0;
    checks++;
    if (rdata !== 32'hFFFF_80FF) begin
      errors++; $display("FAIL lh_signed got %h want ffff80ff", rdata);
    end
  endtask

  task automatic test_sh_delayed;
    logic [31:0] rdata; logic exc; int lat, vld; dbus_req_t snap; bit stable, hold_ok;
    rsp_addr_dly = 3; rsp_data_dly = 2;
    run_op(1'b0, 1'b1, MSIZE2, 1'b0, 32'h8000_0022, 32'h0000_1234, 0, rdata, exc, lat, vld, snap, stable, hold_ok);
    checks++;
    if (vld !== 4 || stable !== 1'b1) begin
      errors++; $display("FAIL sh_hold got vld=%0d stable=%0b want 4/1", vld, stable);
    end
    checks++;
    if (snap.strobe !== 4'b1100 || snap.data !== 32'h1234_0000) begin
      errors++; $display("FAIL sh_lanes got s=%b d=%h want 1100/12340000", snap.strobe, snap.data);
    end
    checks++;
    if (lat !== 7 || rdata !== 32'd0 || exc !== 1'b0) begin
      errors++; $display("FAIL sh_result got lat=%0d d=%h e=%b want 7/0/0", lat, rdata, exc);
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] rdata; logic exc; int lat, vld; dbus_req_t snap; bit stable, hold_ok;
    rsp_addr_dly = 0; rsp_data_dly = 0;
    run_op(1'b1, 1'b0, MSIZE4, 1'b0, 32'h8000_0011, 32'h0, 5, rdata, exc, lat, vld, snap, stable, hold_ok);
    checks++;
    if (exc !== 1'b1 || rdata !== 32'd0 || lat !== 1) begin
      errors++; $display("FAIL misal_result got e=%b d=%h lat=%0d want 1/0/1", exc, rdata, lat);
    end
    checks++;
    if (vld !== 0) begin
      errors++; $display("FAIL misal_nobus got vld=%0d want 0", vld);
    end
    checks++;
    if (hold_ok !== 1'b1) begin
      errors++; $display("FAIL misal_hold got hold_ok=%0b want 1", hold_ok);
    end
  endtask

  task automatic test_back_to_back;
    rsp_addr_dly = 0; rsp_data_dly = 0;
    out_ready = 1'b1;
    in_read = 1'b0; in_write = 1'b1; in_size = MSIZE4; in_signed = 1'b0;
    in_addr = 32'h8000_0004; in_wdata = 32'hAAAA_5555; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first_rdy got %b want 1", in_ready);
    end
    @(negedge clk);
    in_addr = 32'h8000_0008; in_wdata = 32'h1357_9BDF;
    checks++;
    if (dbus.dreq.valid !== 1'b1 || dbus.dreq.addr !== 32'h8000_0004 || in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_req1 got v=%b a=%h rdy=%b want 1/80000004/0", dbus.dreq.valid, dbus.dreq.addr, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_hold got ov=%b rdy=%b want 1/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (dbus.dreq.valid !== 1'b1 || dbus.dreq.addr !== 32'h8000_0008 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_req2 got v=%b a=%h ov=%b want 1/80000008/0", dbus.dreq.valid, dbus.dreq.addr, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_hold2 got ov=%b want 1", out_valid);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (mem_bus[1] !== 32'hAAAA_5555 || mem_bus[2] !== 32'h1357_9BDF) begin
      errors++; $display("FAIL b2b_mem got %h %h want aaaa5555 13579bdf", mem_bus[1], mem_bus[2]);
    end
  endtask

  task automatic test_reset_mid;
    man_en = 1'b1; man_dresp = '0;
    in_read = 1'b1; in_write = 1'b0; in_size = MSIZE4; in_signed = 1'b0;
    in_addr = 32'h8000_0030; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    man_dresp.addr_ok = 1'b1;
    @(negedge clk);
    man_dresp = '0;
    checks++;
    if (dbus.dreq.valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_wait got v=%b ov=%b rdy=%b want 0/0/0", dbus.dreq.valid, out_valid, in_ready);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (dbus.dreq.valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_async got v=%b rdy=%b want 0/1", dbus.dreq.valid, in_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    man_dresp.data_ok = 1'b1;
    man_dresp.data = 32'h1234_5678;
    @(negedge clk);
    man_dresp = '0;
    checks++;
    if (out_valid !== 1'b0 || out_rdata !== 32'd0 || in_ready !== 1'b1 || dbus.dreq.valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_stray got ov=%b d=%h rdy=%b v=%b want 0/0/1/0", out_valid, out_rdata, in_ready, dbus.dreq.valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got ov=%b want 0", out_valid);
    end
    man_en = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] rdata; logic exc; int lat, vld; dbus_req_t snap; bit stable, hold_ok;
    for (int i = 0; i < 16; i++) mem_ref[i] = mem_bus[i];
    for (int t = 0; t < 60; t++) begin
      int          kind, nb, hold;
      logic        rd, wr, sg, misal, go_bus;
      msize_t      sz;
      logic [31:0] ad, wd, exp_d;
      logic [1:0]  off;
      logic [3:0]  idx, exp_s;
      kind = $urandom_range(0, 5);
      rd = (kind == 1 || kind == 2);
      wr = (kind >= 3);
      sz = msize_t'(2'($urandom_range(0, 2)));
      sg = 1'($urandom);
      ad = 32'h1000_0000 | 32'($urandom_range(0, 63));
      wd = $urandom;
      hold = $urandom_range(0, 2);
      rsp_addr_dly = $urandom_range(0, 2);
      rsp_data_dly = $urandom_range(0, 2);
      off = ad[1:0];
      idx = ad[5:2];
      nb = 1 << int'(sz);
      misal = (nb == 2 && off[0]) || (nb == 4 && off != 2'b00);
      go_bus = (rd || wr) && !misal;
      exp_d = '0;
      exp_s = '0;
      if (go_bus && wr) begin
        for (int b = 0; b < nb; b++) begin
          mem_ref[idx][8*(int'(off)+b) +: 8] = wd[8*b +: 8];
          exp_s[int'(off)+b] = 1'b1;
        end
      end
      if (go_bus && rd) begin
        for (int b = 0; b < nb; b++) exp_d[8*b +: 8] = mem_ref[idx][8*(int'(off)+b) +: 8];
        for (int b = nb; b < 4; b++) exp_d[8*b +: 8] = (sg && exp_d[8*nb-1]) ? 8'hFF : 8'h00;
      end
      run_op(rd, wr, sz, sg, ad, wd, hold, rdata, exc, lat, vld, snap, stable, hold_ok);
      checks++;
      if (rdata !== exp_d || exc !== ((rd || wr) && misal)) begin
        errors++; $display("FAIL rand_result op%0d got d=%h e=%b want d=%h e=%b", t, rdata, exc, exp_d, (rd || wr) && misal);
      end
      checks++;
      if ((vld != 0) !== go_bus || hold_ok !== 1'b1) begin
        errors++; $display("FAIL rand_bus op%0d got vld=%0d hold_ok=%0b want bus=%0b hold_ok=1", t, vld, hold_ok, go_bus);
      end
      if (go_bus) begin
        checks++;
        if (snap.strobe !== exp_s || stable !== 1'b1) begin
          errors++; $display("FAIL rand_strobe op%0d got s=%b stable=%0b want s=%b stable=1", t, snap.strobe, stable, exp_s);
        end
        if (rsp_addr_dly == 0 && rsp_data_dly == 0) begin
          checks++;
          if (lat !== 2) begin
            errors++; $display("FAIL rand_lat2 op%0d got %0d want 2", t, lat);
          end
        end
      end else begin
        checks++;
        if (lat !== 1) begin
          errors++; $display("FAIL rand_lat1 op%0d got %0d want 1", t, lat);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem_bus[i] !== mem_ref[i]) begin
        errors++; $display("FAIL rand_mem word%0d got %h want %h", i, mem_bus[i], mem_ref[i]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lw();
    test_lb();
    test_sh_delayed();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
